csr_unit_m: RTL and testbench
=============================

// Module: csr_unit_m
// PURPOSE
//  Parametrised machine-mode CSR unit for the single-issue core. Sits beside the
//  register file: combinational read for csrrw/csrrs/csrrc, atomic set/clear
//  writes, trap entry/return, and 64-bit mcycle/minstret counters. Also does
//  interrupt pending/enable arbitration and returns the trap target PC to the fetch stage.
// PARAMETERS
//  XLEN            32            data width; counters are always 64-bit, split at XLEN=32
//  MTVEC_RESET     32'h0         reset value of mtvec
//  MSCRATCH_RESET  32'h0802_0000 reset value of mscratch
//  HAS_COUNTERS    1             0: mcycle/minstret addresses are illegal
//  VECTORED        1             1: mtvec MODE=01 is legal; 0: mtvec[1:0] forced to 00
// PORTS
//  clk           in   1     clock; all state updates on the falling edge
//  reset_x       in   1     asynchronous active-low reset
//  csr_addr      in   12    CSR address (read and write)
//  csr_op        in   2     00 none, 01 RW, 10 RS (set), 11 RC (clear)
//  csr_rs1_zero  in   1     source is x0/zimm=0; suppresses the write for RS/RC
//  csr_wdata     in   XLEN  rs1 value or zero-extended zimm
//  instret       in   1     one instruction retired this cycle
//  exc           in   1     synchronous exception (ecall, illegal, ...)
//  exc_cause     in   5     exception code (11 = ecall from M)
//  exc_pc        in   XLEN  PC of the faulting instruction
//  exc_tval      in   XLEN  value written to mtval on an exception
//  mret          in   1     mret retiring
//  irq_ext/irq_tim/irq_sw in 1 each  level interrupt lines
//  csr_rdata     out  XLEN  old CSR value (combinational)
//  csr_illegal   out  1     bad address, or write attempt to a read-only CSR
//  irq_take      out  1     interrupt accepted this cycle
//  trap_pc       out  XLEN  redirect target: trap vector on exc/irq_take, mepc on mret
// BEHAVIOUR
//  Reset: mstatus=32'h0000_1888 (MIE=1, MPIE=1, MPP=11), mie=0, mtvec=MTVEC_RESET,
//   mscratch=MSCRATCH_RESET, mepc/mcause/mtval=0, counters=0. Outputs are
//   combinational from this state: csr_illegal=0 when csr_op=00, irq_take=0.
//  Map: 300 mstatus, 304 mie, 305 mtvec, 340 mscratch, 341 mepc, 342 mcause,
//   343 mtval, 344 mip; B00/B80 mcycle lo/hi, B02/B82 minstret lo/hi;
//   C00/C80/C02/C82 read-only shadows. Any other address: csr_illegal=1, rdata=0.
//  Read-only: addr[11:10]==11 or mip. A write there with csr_op!=00 asserts
//   csr_illegal and changes no state. RS/RC with csr_rs1_zero=1 is a pure read: legal.
//  Write value: RW=wdata; RS=old|wdata; RC=old&~wdata. Applied at the next falling edge.
//  Masks: mstatus writes only bits 3 and 7; MPP stays 11; other bits read 0.
//   mie writes only bits 3, 7, 11. mepc[1:0] is forced to 00. mtvec[1] is
//   forced to 0, and mtvec[0] is forced to 0 when VECTORED=0.
//  mip: bits 11/7/3 = irq_ext/irq_tim/irq_sw, registered each edge; no other bits.
//  Counters: mcycle+1 every edge. minstret+1 on edges where instret=1. A CSR write
//   to either half replaces that half, and that counter does not increment that
//   edge. Wrap 2^64-1 -> 0.
//  irq_take = mstatus[3] & |(mip & mie) & ~exc & ~mret.
//   Cause priority: ext(11) > sw(3) > tim(7).
//  Event priority in one cycle: exc > irq_take > mret > CSR write. The CSR write
//   is dropped when any of the other three occurs. Counters still update.
//  Trap entry (exc or irq_take): mepc<=exc_pc, MPIE<=MIE, MIE<=0.
//   mcause<={irq,26'b0,code}; mtval<=exc_tval for exc, 0 for irq.
//  mret: MIE<=MPIE, MPIE<=1.
//  trap_pc: exc -> mtvec base {mtvec[XLEN-1:2],2'b00}. irq with MODE=01 ->
//   base + 4*code. mret -> mepc. Else 0.
//  Reset mid-operation: all state returns to reset values immediately; a
//   pending write is lost.
// TESTING
//  1 reset_x low mid-run -> mstatus reads 32'h1888, mscratch 32'h0802_0000, mcycle 0
//  2 RW 300 <- FFFF_FFFF -> reads 32'h1888; RS 304 0x800 then RC 304 0x800 -> mie 0x800, then 0
//  3 write C00, or RW 344 -> csr_illegal=1, no state change; RS C00 with rs1_zero -> legal read
//  4 mcycle=FFFF_FFFF_FFFF_FFFF -> next edge 0; RW B00<-5 with instret=1 -> mcycle lo=5, minstret+1
//  5 exc cause 11, pc 0x100 -> mepc 0x100, mcause 11, MIE 0, trap_pc=mtvec base; mret -> MIE 1, trap_pc 0x100
//  6 mtvec=0x201, mie=0x888, ext+tim high -> irq_take, mcause 0x8000_000B, trap_pc 0x22C; exc same cycle -> exc wins

Source files
------------

// File: rtl/csr_unit_m.sv
// Machine-mode CSR unit: combinational CSR read, RW/RS/RC writes, trap entry/return,
// interrupt arbitration and 64-bit mcycle/minstret. All state advances on the falling clock edge.
module csr_unit_m #(
    parameter int          XLEN           = 32,
    parameter logic [31:0] MTVEC_RESET    = 32'h0,
    parameter logic [31:0] MSCRATCH_RESET = 32'h0802_0000,
    parameter bit          HAS_COUNTERS   = 1'b1,
    parameter bit          VECTORED       = 1'b1
) (
    input  logic            clk,
    input  logic            reset_x,
    input  logic [11:0]     csr_addr,
    input  logic [1:0]      csr_op,
    input  logic            csr_rs1_zero,
    input  logic [XLEN-1:0] csr_wdata,
    input  logic            instret,
    input  logic            exc,
    input  logic [4:0]      exc_cause,
    input  logic [XLEN-1:0] exc_pc,
    input  logic [XLEN-1:0] exc_tval,
    input  logic            mret,
    input  logic            irq_ext,
    input  logic            irq_tim,
    input  logic            irq_sw,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    output logic            irq_take,
    output logic [XLEN-1:0] trap_pc
);
    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_RS   = 2'b10;

    // mie/mip only hold bits {11,7,3} = {ext, tim, sw}
    logic            mie_bit_q, mie_bit_d;
    logic            mpie_q, mpie_d;
    logic [2:0]      mie_q, mie_d;
    logic [2:0]      mip_q, mip_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mtval_q, mtval_d;
    logic [63:0]     mcycle_q, mcycle_d;
    logic [63:0]     minstret_q, minstret_d;

    logic [XLEN-1:0] mstatus_rd, mie_rd, mip_rd;
    logic [XLEN-1:0] old_val, wval, trap_base;
    logic            addr_valid, read_only, write_try, wr_en, trap;
    logic [2:0]      pend;
    logic [4:0]      irq_code;

    always_comb begin
        mstatus_rd        = '0;
        mstatus_rd[12:11] = 2'b11;
        mstatus_rd[7]     = mpie_q;
        mstatus_rd[3]     = mie_bit_q;
        mie_rd            = '0;
        mie_rd[11]        = mie_q[2];
        mie_rd[7]         = mie_q[1];
        mie_rd[3]         = mie_q[0];
        mip_rd            = '0;
        mip_rd[11]        = mip_q[2];
        mip_rd[7]         = mip_q[1];
        mip_rd[3]         = mip_q[0];
    end

    always_comb begin
        addr_valid = 1'b1;
        old_val    = '0;
        case (csr_addr)
            12'h300: old_val = mstatus_rd;
            12'h304: old_val = mie_rd;
            12'h305: old_val = mtvec_q;
            12'h340: old_val = mscratch_q;
            12'h341: old_val = mepc_q;
            12'h342: old_val = mcause_q;
            12'h343: old_val = mtval_q;
            12'h344: old_val = mip_rd;
            12'hB00, 12'hC00: begin
                addr_valid = HAS_COUNTERS;
                old_val    = XLEN'(mcycle_q[31:0]);
            end
            12'hB80, 12'hC80: begin
                addr_valid = HAS_COUNTERS;
                old_val    = XLEN'(mcycle_q[63:32]);
            end
            12'hB02, 12'hC02: begin
                addr_valid = HAS_COUNTERS;
                old_val    = XLEN'(minstret_q[31:0]);
            end
            12'hB82, 12'hC82: begin
                addr_valid = HAS_COUNTERS;
                old_val    = XLEN'(minstret_q[63:32]);
            end
            default: addr_valid = 1'b0;
        endcase
        if (!addr_valid) begin
            old_val = '0;
        end
    end

    assign csr_rdata   = old_val;
    assign read_only   = (csr_addr[11:10] == 2'b11) || (csr_addr == 12'h344);
    assign write_try   = (csr_op == OP_RW) || !csr_rs1_zero;
    assign csr_illegal = (csr_op != OP_NONE) && (!addr_valid || (read_only && write_try));

    assign pend     = mip_q & mie_q;
    assign irq_take = mie_bit_q && (|pend) && !exc && !mret;
    assign irq_code = pend[2] ? 5'd11 : (pend[0] ? 5'd3 : 5'd7);
    assign trap     = exc || irq_take;
    // A CSR write only lands when no trap or mret claims the cycle
    assign wr_en    = (csr_op != OP_NONE) && addr_valid && !read_only && write_try
                      && !trap && !mret;

    always_comb begin
        case (csr_op)
            OP_RW:   wval = csr_wdata;
            OP_RS:   wval = old_val | csr_wdata;
            default: wval = old_val & ~csr_wdata;
        endcase
    end

    assign trap_base = {mtvec_q[XLEN-1:2], 2'b00};

    always_comb begin
        if (exc) begin
            trap_pc = trap_base;
        end else if (irq_take) begin
            trap_pc = mtvec_q[0] ? trap_base + {{(XLEN-7){1'b0}}, irq_code, 2'b00} : trap_base;
        end else if (mret) begin
            trap_pc = mepc_q;
        end else begin
            trap_pc = '0;
        end
    end

    always_comb begin
        mie_bit_d  = mie_bit_q;
        mpie_d     = mpie_q;
        mie_d      = mie_q;
        mip_d      = {irq_ext, irq_tim, irq_sw};
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = minstret_q + {63'd0, instret};

        if (trap) begin
            mepc_d         = {exc_pc[XLEN-1:2], 2'b00};
            mcause_d       = '0;
            mcause_d[XLEN-1] = !exc;
            mcause_d[4:0]  = exc ? exc_cause : irq_code;
            mtval_d        = exc ? exc_tval : '0;
            mpie_d         = mie_bit_q;
            mie_bit_d      = 1'b0;
        end else if (mret) begin
            mie_bit_d = mpie_q;
            mpie_d    = 1'b1;
        end

        if (wr_en) begin
            case (csr_addr)
                12'h300: begin
                    mie_bit_d = wval[3];
                    mpie_d    = wval[7];
                end
                12'h304: mie_d      = {wval[11], wval[7], wval[3]};
                12'h305: mtvec_d    = {wval[XLEN-1:2], 1'b0, VECTORED ? wval[0] : 1'b0};
                12'h340: mscratch_d = wval;
                12'h341: mepc_d     = {wval[XLEN-1:2], 2'b00};
                12'h342: mcause_d   = wval;
                12'h343: mtval_d    = wval;
                12'hB00: mcycle_d   = {mcycle_q[63:32], wval[31:0]};
                12'hB80: mcycle_d   = {wval[31:0], mcycle_q[31:0]};
                12'hB02: minstret_d = {minstret_q[63:32], wval[31:0]};
                12'hB82: minstret_d = {wval[31:0], minstret_q[31:0]};
                default: ;
            endcase
        end
    end

    always_ff @(negedge clk or negedge reset_x) begin
        if (!reset_x) begin
            mie_bit_q  <= 1'b1;
            mpie_q     <= 1'b1;
            mie_q      <= '0;
            mip_q      <= '0;
            mtvec_q    <= XLEN'(MTVEC_RESET);
            mscratch_q <= XLEN'(MSCRATCH_RESET);
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mie_bit_q  <= mie_bit_d;
            mpie_q     <= mpie_d;
            mie_q      <= mie_d;
            mip_q      <= mip_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end
endmodule

// File: tb/tb_csr_unit_m.sv
// Bench for csr_unit_m: directed scenarios with literal expectations, then random traffic
// compared every cycle against a register-level behavioural model.
module tb_csr_unit_m;
    logic        clk = 1'b0;
    logic        reset_x = 1'b0;
    logic [11:0] csr_addr = '0;
    logic [1:0]  csr_op = '0;
    logic        csr_rs1_zero = 1'b0;
    logic [31:0] csr_wdata = '0;
    logic        instret = 1'b0;
    logic        exc = 1'b0;
    logic [4:0]  exc_cause = '0;
    logic [31:0] exc_pc = '0;
    logic [31:0] exc_tval = '0;
    logic        mret = 1'b0;
    logic        irq_ext = 1'b0, irq_tim = 1'b0, irq_sw = 1'b0;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        irq_take;
    logic [31:0] trap_pc;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_mip;
    logic [63:0] m_mcycle, m_minstret;

    csr_unit_m dut (
        .clk(clk), .reset_x(reset_x), .csr_addr(csr_addr), .csr_op(csr_op),
        .csr_rs1_zero(csr_rs1_zero), .csr_wdata(csr_wdata), .instret(instret),
        .exc(exc), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
        .mret(mret), .irq_ext(irq_ext), .irq_tim(irq_tim), .irq_sw(irq_sw),
        .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .irq_take(irq_take),
        .trap_pc(trap_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic model_reset();
        m_mstatus  = 32'h0000_1888;
        m_mie      = 32'h0;
        m_mtvec    = 32'h0;
        m_mscratch = 32'h0802_0000;
        m_mepc     = 32'h0;
        m_mcause   = 32'h0;
        m_mtval    = 32'h0;
        m_mip      = 32'h0;
        m_mcycle   = 64'h0;
        m_minstret = 64'h0;
    endtask

    function automatic bit m_valid(input logic [11:0] a);
        case (a)
            12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
            12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'h344: return m_mip;
            12'hB00, 12'hC00: return m_mcycle[31:0];
            12'hB80, 12'hC80: return m_mcycle[63:32];
            12'hB02, 12'hC02: return m_minstret[31:0];
            12'hB82, 12'hC82: return m_minstret[63:32];
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit m_ro(input logic [11:0] a);
        return (a[11:10] == 2'b11) || (a == 12'h344);
    endfunction

    function automatic bit m_illegal();
        if (csr_op == 2'b00) return 1'b0;
        return !m_valid(csr_addr) || (m_ro(csr_addr) && (csr_op == 2'b01 || !csr_rs1_zero));
    endfunction

    function automatic bit m_irq();
        return m_mstatus[3] && ((m_mip & m_mie) != 0) && !exc && !mret;
    endfunction

    function automatic logic [31:0] m_code();
        logic [31:0] p;
        p = m_mip & m_mie;
        if (p[11]) return 32'd11;
        if (p[3])  return 32'd3;
        return 32'd7;
    endfunction

    function automatic logic [31:0] m_trap_pc();
        logic [31:0] base;
        base = m_mtvec & ~32'h3;
        if (exc) return base;
        if (m_irq()) return (m_mtvec[1:0] == 2'b01) ? base + 4 * m_code() : base;
        if (mret) return m_mepc;
        return 32'h0;
    endfunction

    task automatic model_step();
        bit          irq, cyc_wr, ins_wr;
        logic [31:0] old, v;
        irq    = m_irq();
        cyc_wr = 1'b0;
        ins_wr = 1'b0;
        if (exc || irq) begin
            m_mepc    = exc_pc & ~32'h3;
            m_mcause  = exc ? {27'h0, exc_cause} : (32'h8000_0000 | m_code());
            m_mtval   = exc ? exc_tval : 32'h0;
            m_mstatus = 32'h1800 | (m_mstatus[3] ? 32'h80 : 32'h0);
        end else if (mret) begin
            m_mstatus = 32'h1880 | (m_mstatus[7] ? 32'h8 : 32'h0);
        end else if (csr_op != 2'b00 && !m_illegal() && (csr_op == 2'b01 || !csr_rs1_zero)) begin
            old = m_read(csr_addr);
            v = (csr_op == 2'b01) ? csr_wdata : (csr_op == 2'b10) ? (old | csr_wdata) : (old & ~csr_wdata);
            case (csr_addr)
                12'h300: m_mstatus = (v & 32'h88) | 32'h1800;
                12'h304: m_mie = v & 32'h888;
                12'h305: m_mtvec = v & ~32'h2;
                12'h340: m_mscratch = v;
                12'h341: m_mepc = v & ~32'h3;
                12'h342: m_mcause = v;
                12'h343: m_mtval = v;
                12'hB00: begin m_mcycle[31:0] = v;    cyc_wr = 1'b1; end
                12'hB80: begin m_mcycle[63:32] = v;   cyc_wr = 1'b1; end
                12'hB02: begin m_minstret[31:0] = v;  ins_wr = 1'b1; end
                12'hB82: begin m_minstret[63:32] = v; ins_wr = 1'b1; end
                default: ;
            endcase
        end
        if (!cyc_wr) m_mcycle = m_mcycle + 64'd1;
        if (!ins_wr && instret) m_minstret = m_minstret + 64'd1;
        m_mip = (irq_ext ? 32'h800 : 32'h0) | (irq_tim ? 32'h80 : 32'h0) | (irq_sw ? 32'h8 : 32'h0);
    endtask

    always @(negedge clk) begin
        if (reset_x) model_step();
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t addr=%h got=%h expected=%h", name, $time, csr_addr, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (reset_x && chk_en) begin
            cmp("rdata", csr_rdata, m_read(csr_addr));
            cmp("illegal", {31'h0, csr_illegal}, {31'h0, m_illegal()});
            cmp("irq_take", {31'h0, irq_take}, {31'h0, m_irq()});
            cmp("trap_pc", trap_pc, m_trap_pc());
        end
    end

    task automatic nxt();
        @(negedge clk);
        #1;
        csr_op       = 2'b00;
        csr_rs1_zero = 1'b0;
        exc          = 1'b0;
        mret         = 1'b0;
        instret      = 1'b0;
    endtask

    task automatic samp();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
        nxt();
        csr_op    = op;
        csr_addr  = a;
        csr_wdata = d;
    endtask

    task automatic rd_lit(input string name, input logic [11:0] a, input logic [31:0] exp);
        nxt();
        csr_addr = a;
        samp();
        cmp(name, csr_rdata, exp);
    endtask

    logic [11:0] addr_tab [18] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                   12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
                                   12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'h301, 12'h7C0};

    initial begin
        model_reset();
        // reset state, observed while reset is held
        #12;
        csr_addr = 12'h300; #1 cmp("rst_mstatus", csr_rdata, 32'h0000_1888);
        csr_addr = 12'h340; #1 cmp("rst_mscratch", csr_rdata, 32'h0802_0000);
        csr_addr = 12'hB00; #1 cmp("rst_mcycle", csr_rdata, 32'h0);
        cmp("rst_irq_take", {31'h0, irq_take}, 32'h0);
        cmp("rst_illegal", {31'h0, csr_illegal}, 32'h0);
        cmp("rst_trap_pc", trap_pc, 32'h0);
        @(negedge clk);
        #1 reset_x = 1'b1;
        chk_en = 1'b1;

        // mstatus masking and mie set/clear
        wr(2'b01, 12'h300, 32'hFFFF_FFFF);
        rd_lit("mstatus_ones", 12'h300, 32'h0000_1888);
        wr(2'b01, 12'h300, 32'h0);
        rd_lit("mstatus_zero", 12'h300, 32'h0000_1800);
        wr(2'b01, 12'h300, 32'h88);
        wr(2'b10, 12'h304, 32'h800);
        rd_lit("mie_set", 12'h304, 32'h800);
        wr(2'b11, 12'h304, 32'h800);
        rd_lit("mie_clr", 12'h304, 32'h0);

        // read-only and illegal accesses
        wr(2'b01, 12'hC00, 32'h5);
        samp(); cmp("ro_c00_illegal", {31'h0, csr_illegal}, 32'h1);
        wr(2'b01, 12'h344, 32'h888);
        samp(); cmp("ro_mip_illegal", {31'h0, csr_illegal}, 32'h1);
        rd_lit("mip_unchanged", 12'h344, 32'h0);
        wr(2'b10, 12'hC00, 32'hFFFF);
        csr_rs1_zero = 1'b1;
        samp(); cmp("rs_zero_legal", {31'h0, csr_illegal}, 32'h0);
        wr(2'b00, 12'h123, 32'h0);
        samp(); cmp("bad_addr_noop", {31'h0, csr_illegal}, 32'h0);
        cmp("bad_addr_rdata", csr_rdata, 32'h0);
        wr(2'b01, 12'h123, 32'h1);
        samp(); cmp("bad_addr_write", {31'h0, csr_illegal}, 32'h1);

        // counter wrap and write-vs-increment
        wr(2'b01, 12'hB80, 32'hFFFF_FFFF);
        wr(2'b01, 12'hB00, 32'hFFFF_FFFF);
        rd_lit("mcycle_max", 12'hB00, 32'hFFFF_FFFF);
        rd_lit("mcycle_wrap_hi", 12'hB80, 32'h0);
        rd_lit("mcycle_after_wrap", 12'hB00, 32'h1);
        wr(2'b01, 12'hB02, 32'h10);
        wr(2'b01, 12'hB82, 32'h0);
        wr(2'b01, 12'hB00, 32'h5);
        instret = 1'b1;
        rd_lit("mcycle_written", 12'hB00, 32'h5);
        rd_lit("minstret_inc", 12'hB02, 32'h11);

        // exception entry (concurrent CSR write dropped) and mret
        wr(2'b01, 12'h305, 32'h1000);
        wr(2'b01, 12'h340, 32'hDEAD);
        exc = 1'b1; exc_cause = 5'd11; exc_pc = 32'h100; exc_tval = 32'h55;
        samp(); cmp("exc_trap_pc", trap_pc, 32'h1000);
        rd_lit("exc_mscratch_kept", 12'h340, 32'h0802_0000);
        rd_lit("exc_mepc", 12'h341, 32'h100);
        rd_lit("exc_mcause", 12'h342, 32'hB);
        rd_lit("exc_mtval", 12'h343, 32'h55);
        rd_lit("exc_mstatus", 12'h300, 32'h1880);
        nxt(); mret = 1'b1;
        samp(); cmp("mret_trap_pc", trap_pc, 32'h100);
        rd_lit("mret_mstatus", 12'h300, 32'h1888);

        // vectored interrupt, then exception overriding an interrupt
        wr(2'b01, 12'h305, 32'h203);
        exc_pc = 32'h300;
        wr(2'b01, 12'h304, 32'h888);
        irq_ext = 1'b1; irq_tim = 1'b1;
        nxt(); csr_addr = 12'h305;
        samp();
        cmp("mtvec_masked", csr_rdata, 32'h201);
        cmp("irq_take_ext", {31'h0, irq_take}, 32'h1);
        cmp("irq_trap_pc", trap_pc, 32'h22C);
        rd_lit("irq_mcause", 12'h342, 32'h8000_000B);
        rd_lit("irq_mepc", 12'h341, 32'h300);
        nxt(); mret = 1'b1;
        samp(); cmp("irq_mret_pc", trap_pc, 32'h300);
        nxt(); exc = 1'b1; exc_cause = 5'd2;
        samp();
        cmp("exc_beats_irq", {31'h0, irq_take}, 32'h0);
        cmp("exc_beats_irq_pc", trap_pc, 32'h200);
        rd_lit("exc_beats_mcause", 12'h342, 32'h2);
        nxt(); mret = 1'b1; irq_ext = 1'b0; irq_tim = 1'b0;

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            nxt();
            csr_addr     = ($urandom_range(0, 9) == 0) ? 12'($urandom) : addr_tab[$urandom_range(0, 17)];
            csr_op       = 2'($urandom);
            csr_rs1_zero = ($urandom_range(0, 3) == 0);
            csr_wdata    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            instret      = 1'($urandom);
            exc          = ($urandom_range(0, 15) == 0);
            mret         = ($urandom_range(0, 15) == 0);
            exc_cause    = 5'($urandom);
            exc_pc       = $urandom;
            exc_tval     = $urandom;
            if ($urandom_range(0, 7) == 0) begin
                irq_ext = 1'($urandom); irq_tim = 1'($urandom); irq_sw = 1'($urandom);
            end
            if (i % 800 == 400) begin
                #2 reset_x = 1'b0;
                model_reset();
                @(negedge clk);
                #1 reset_x = 1'b1;
            end
        end

        // reset mid-operation with a write pending
        wr(2'b01, 12'h340, 32'h1234);
        #2 reset_x = 1'b0;
        model_reset();
        csr_op = 2'b00;
        csr_addr = 12'h300; #1 cmp("mid_rst_mstatus", csr_rdata, 32'h0000_1888);
        csr_addr = 12'h340; #1 cmp("mid_rst_mscratch", csr_rdata, 32'h0802_0000);
        csr_addr = 12'hB00; #1 cmp("mid_rst_mcycle", csr_rdata, 32'h0);
        @(negedge clk);
        #1 reset_x = 1'b1;
        rd_lit("mid_rst_write_lost", 12'h340, 32'h0802_0000);
        nxt();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
